alu: RTL and testbench
======================

// Module: alu
// PURPOSE
// - Registered 4-function signed integer ALU: add, subtract, multiply, divide.
// - Operands are 32-bit two's complement; the result is 64-bit two's complement,
//   so add, sub and mul never overflow.
// - Sits in the datapath as a leaf compute block; one operation per cycle, fully pipelined.
// PARAMETERS
// - DATA_W    32   operand width (a, b), signed
// - RES_W     64   result width, must be >= 2*DATA_W
// PORTS
// - clk          in   1       single clock, all state on rising edge
// - rst_n        in   1       reset, asynchronous assert, active-low
// - in_valid     in   1       opcode/a/b are valid this cycle
// - opcode       in   2       0=ADD 1=SUB 2=MUL 3=DIV
// - a            in   DATA_W  operand A, signed
// - b            in   DATA_W  operand B, signed
// - result       out  RES_W   registered signed result
// - out_valid    out  1       result/div_by_zero valid (in_valid delayed 1 cycle)
// - div_by_zero  out  1       DIV issued with b==0
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): result=0, out_valid=0, div_by_zero=0; held until rst_n rises.
// - Latency 1: inputs are sampled on the rising edge where in_valid=1; result and
//   out_valid=1 appear after that edge.
// - The cycle after in_valid=0: out_valid=0; result and div_by_zero hold their last values.
// - No backpressure; a new operation is accepted every cycle.
// - All ops sign-extend a and b to RES_W before computing.
//   - ADD: a+b.
//   - SUB: a-b.
//   - MUL: full signed product, exact in RES_W.
// - DIV: signed quotient, truncated toward zero (-7/2 = -3); remainder discarded.
//   - -2^31 / -1 = +2^31, exact in RES_W.
//   - b==0: result=0, div_by_zero=1.
//   - div_by_zero=0 for every other op and for any DIV with b!=0.
// - Division is single-cycle combinational (tool-inferred); no iterative divider.
// - Reset asserted mid-stream: the in-flight op is discarded; out_valid=0 immediately.
// - Outputs change only on clk edges or reset, never combinationally from inputs.
// TESTING
// - Reset, then idle: result=0, out_valid=0, div_by_zero=0.
// - Basic ops, a=12, b=10: ADD->22, SUB->2, MUL->120; a=12,b=2 DIV->6;
//   each result appears one cycle after issue with out_valid=1.
// - Back-to-back stream, one op per cycle:
//   SUB 50,20->30; MUL 60,100->6000; DIV 50,10->5; MUL 100,3->300; SUB 40,20->20.
// - Sign/width:
//   - SUB 0,1 -> -1 (all 64 bits set).
//   - MUL 0x7FFFFFFF,0x7FFFFFFF -> 0x3FFFFFFF00000001.
//   - DIV -7,2 -> -3.
//   - DIV -2^31,-1 -> 2^31.
// - DIV 5,0 -> result=0, div_by_zero=1; next op ADD 1,1 -> 2 with div_by_zero=0.
// - Assert rst_n low asynchronously mid-stream: outputs clear without a clock edge;
//   after release, the first op result is correct.

Source files
------------

// File: rtl/alu.sv
// rtl/alu.sv - registered signed add/sub/mul/div ALU, latency 1
module alu #(
  parameter int DATA_W = 32,
  parameter int RES_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  result,
  output logic              out_valid,
  output logic              div_by_zero
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] divisor;
  logic signed [RES_W-1:0] res_c;
  logic                    b_zero;
  logic                    dbz_c;

  assign a_ext  = {{(RES_W-DATA_W){a[DATA_W-1]}}, a};
  assign b_ext  = {{(RES_W-DATA_W){b[DATA_W-1]}}, b};
  assign b_zero = (b == '0);
  // Keep the divider away from a zero divisor; the result is forced to 0 anyway.
  assign divisor = b_zero ? RES_W'(1) : b_ext;

  always_comb begin
    res_c = '0;
    dbz_c = 1'b0;
    case (opcode)
      OP_ADD: res_c = a_ext + b_ext;
      OP_SUB: res_c = a_ext - b_ext;
      OP_MUL: res_c = a_ext * b_ext;
      OP_DIV: begin
        if (b_zero) begin
          res_c = '0;
          dbz_c = 1'b1;
        end else begin
          res_c = a_ext / divisor;
        end
      end
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result      <= res_c;
        div_by_zero <= dbz_c;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed-vector self-checking bench for alu
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        out_valid;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  alu #(.DATA_W(32), .RES_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .result      (result),
    .out_valid   (out_valid),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [63:0] exp_res, input logic exp_dbz);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
    check({tag, ".result"}, result, exp_res);
    check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, ".dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
  endtask

  task automatic idle(input string tag, input logic [63:0] hold_res, input logic hold_dbz);
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 2'd2;
    a        = 32'd9;
    b        = 32'd0;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, ".hold_res"}, result, hold_res);
    check({tag, ".hold_dbz"}, {63'd0, div_by_zero}, {63'd0, hold_dbz});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = 2'd0;
    a        = 32'd0;
    b        = 32'd0;
    #3;
    check("rst_async.result", result, 64'd0);
    check("rst_async.valid", {63'd0, out_valid}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle.result", result, 64'd0);
    check("idle.valid", {63'd0, out_valid}, 64'd0);
    check("idle.dbz", {63'd0, div_by_zero}, 64'd0);

    run_op("add12_10", 2'd0, 32'd12, 32'd10, 64'd22, 1'b0);
    run_op("sub12_10", 2'd1, 32'd12, 32'd10, 64'd2, 1'b0);
    run_op("mul12_10", 2'd2, 32'd12, 32'd10, 64'd120, 1'b0);
    run_op("div12_2", 2'd3, 32'd12, 32'd2, 64'd6, 1'b0);
    idle("idle1", 64'd6, 1'b0);

    run_op("s_sub", 2'd1, 32'd50, 32'd20, 64'd30, 1'b0);
    run_op("s_mul", 2'd2, 32'd60, 32'd100, 64'd6000, 1'b0);
    run_op("s_div", 2'd3, 32'd50, 32'd10, 64'd5, 1'b0);
    run_op("s_mul2", 2'd2, 32'd100, 32'd3, 64'd300, 1'b0);
    run_op("s_sub2", 2'd1, 32'd40, 32'd20, 64'd20, 1'b0);

    run_op("sub0_1", 2'd1, 32'd0, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("mulmax", 2'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
    run_op("divneg7", 2'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("divmin", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_op("mulneg", 2'd2, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);

    run_op("div5_0", 2'd3, 32'd5, 32'd0, 64'd0, 1'b1);
    idle("idle_dbz", 64'd0, 1'b1);
    run_op("div5_0b", 2'd3, 32'd5, 32'd0, 64'd0, 1'b1);
    run_op("add1_1", 2'd0, 32'd1, 32'd1, 64'd2, 1'b0);

    // Reset mid-stream, away from any clock edge, with an op still presented.
    run_op("pre_rst", 2'd2, 32'd7, 32'd6, 64'd42, 1'b0);
    in_valid = 1'b1;
    opcode   = 2'd0;
    a        = 32'd100;
    b        = 32'd200;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst.result", result, 64'd0);
    check("mid_rst.valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst.dbz", {63'd0, div_by_zero}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_held.result", result, 64'd0);
    check("rst_held.valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    run_op("post_rst", 2'd0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    idle("idle_end", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
